// File: rtl/vga_sync_timing.sv
// vga_sync_timing
// Raster timing generator for 640x480@60 Hz VGA (parameterisable).
// Produces horizontal/vertical position counters, sync pulses, an
// active-video flag, line/frame strobes and a wrapping frame counter.
// Every output is a register. The flags are decoded from the counters'
// next-state values, so each flag describes the same pixel as the
// hpos/vpos presented in the same cycle.
module vga_sync_timing #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int FC_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic [9:0]          hpos,
    output logic [9:0]          vpos,
    output logic                hsync,
    output logic                vsync,
    output logic                display_on,
    output logic                line_start,
    output logic                frame_start,
    output logic [FC_WIDTH-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Counter end points and decode windows, pre-sized to the counter width
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Level driven on the sync pins while inside a sync window
    localparam logic SYNC_ACTIVE = (SYNC_POL != 0);

    // The counters are 10 bits wide; larger rasters cannot be represented
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
            $error("vga_sync_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    // Position / frame state
    logic [9:0]          hpos_reg;
    logic [9:0]          vpos_reg;
    logic [FC_WIDTH-1:0] fc_reg;
    logic [9:0]          hpos_next;
    logic [9:0]          vpos_next;
    logic [FC_WIDTH-1:0] fc_next;

    // Low for the single cycle after reset: the first non-reset edge must
    // present pixel (0,0) again, now with its flags, so the counters hold.
    logic                running_reg;

    // Registered flags and their decoded next values
    logic hsync_reg, hsync_next;
    logic vsync_reg, vsync_next;
    logic display_on_reg, display_on_next;
    logic line_start_reg, line_start_next;
    logic frame_start_reg, frame_start_next;

    // Next-state counter arithmetic: horizontal wraps every line, vertical
    // advances on the horizontal wrap, frame counter on the vertical wrap
    always_comb begin
        hpos_next = hpos_reg;
        vpos_next = vpos_reg;
        fc_next   = fc_reg;
        if (running_reg) begin
            if (hpos_reg == H_LAST) begin
                hpos_next = 10'd0;
                if (vpos_reg == V_LAST) begin
                    vpos_next = 10'd0;
                    fc_next   = fc_reg + FC_WIDTH'(1);
                end else begin
                    vpos_next = vpos_reg + 10'd1;
                end
            end else begin
                hpos_next = hpos_reg + 10'd1;
            end
        end
    end

    // Flag decode from the next-state counters so flags align with hpos/vpos
    always_comb begin
        hsync_next       = (hpos_next >= HS_FIRST && hpos_next <= HS_LAST)
                           ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next       = (vpos_next >= VS_FIRST && vpos_next <= VS_LAST)
                           ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_on_next  = (hpos_next < H_ACT) && (vpos_next < V_ACT);
        line_start_next  = (hpos_next == 10'd0);
        frame_start_next = (hpos_next == 10'd0) && (vpos_next == 10'd0);
    end

    // State and output registers; reset forces the idle raster immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_reg        <= 10'd0;
            vpos_reg        <= 10'd0;
            fc_reg          <= '0;
            running_reg     <= 1'b0;
            hsync_reg       <= ~SYNC_ACTIVE;
            vsync_reg       <= ~SYNC_ACTIVE;
            display_on_reg  <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            hpos_reg        <= hpos_next;
            vpos_reg        <= vpos_next;
            fc_reg          <= fc_next;
            running_reg     <= 1'b1;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            display_on_reg  <= display_on_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign hpos        = hpos_reg;
    assign vpos        = vpos_reg;
    assign frame_count = fc_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign display_on  = display_on_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock: horizontal and vertical counters, sync pulses, active-video flag, line and frame strobes, and a free-running frame counter.
- Sits directly upstream of the pride-flag pattern generator inside tt_um_rebeccargb_vga_pride.
- The pattern generator consumes hpos/vpos/display_on to select colour and frame_count to animate.
- hsync/vsync go straight to the TinyVGA Pmod pins on uo_out.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, per the VGA 640x480 standard)
- FC_WIDTH, 8, frame_count width

Ports:
- clk  input  1  pixel clock, 25.175 MHz nominal
- reset  input  1  synchronous, active-high
- hpos  output  10  current horizontal position, 0..H_TOTAL-1
- vpos  output  10  current vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- display_on  output  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- line_start  output  1  one-clock pulse when hpos == 0
- frame_start  output  1  one-clock pulse when hpos == 0 and vpos == 0
- frame_count  output  FC_WIDTH  frames completed since reset, wraps

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registered; there is no combinational path from counters to pins.
- hsync, vsync, display_on, line_start and frame_start are decoded from next-state counter values, so every flag describes the same pixel as the hpos/vpos in the same cycle.
- Reset values, while reset is high:
  - hpos = 0, vpos = 0, frame_count = 0.
  - hsync = vsync = !SYNC_POL (inactive).
  - display_on = 0, line_start = 0, frame_start = 0.
- First cycle after reset deasserts:
  - hpos = 0, vpos = 0.
  - display_on = 1, line_start = 1, frame_start = 1.
  - frame_count stays 0.
- Horizontal counter:
  - Increments by 1 every clock.
  - At H_TOTAL-1, the next value is 0.
- Vertical counter:
  - Increments only on the clock where hpos wraps.
  - When vpos = V_TOTAL-1 and hpos wraps, the next vpos is 0.
- frame_count:
  - Increments by 1 on the same clock that vpos wraps, i.e. it is already updated in the cycle where frame_start = 1.
  - Wraps 2^FC_WIDTH-1 -> 0 silently.
- hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- vsync is active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491, for full lines (hpos 0..799).
- display_on is 0 throughout the porches and sync regions.
- Reset asserted mid-frame: next clock forces all reset values regardless of counter state; no partial-frame completion or frame_count increment.
- Counters are sized to 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported; a synthesis-time check must fail in that case.
- One pixel per clock; there is no clock enable.

Test Plan:
- Reset: hold reset 3 clocks from an arbitrary state -> hpos = 0, vpos = 0, hsync = vsync = 1, display_on = 0, frame_count = 0. First cycle after release -> display_on = 1, line_start = 1, frame_start = 1.
- Line timing:
  - display_on = 1 at hpos 639 and 0 at hpos 640.
  - hsync low for exactly 96 clocks, hpos 656..751.
  - hpos 799 -> 0 with vpos 0 -> 1 and a single-cycle line_start.
  - Line period is 800 clocks.
- Frame timing:
  - vsync low for vpos 490..491 (1600 clocks).
  - At hpos = 799, vpos = 524 the next cycle gives hpos = vpos = 0, frame_start = 1, frame_count 0 -> 1.
  - Frame period is 420000 clocks; the frame_start period is checked over 3 frames.
- frame_count wrap, using small params (H 8/1/2/1, V 4/1/1/1, FC_WIDTH = 3): after 8 frames frame_count returns 0, with exactly one frame_start per 12x7 = 84 clocks.
- Mid-frame reset: pulse reset for 1 clock at hpos = 300, vpos = 200, frame_count = 5 -> next cycle shows reset values. Timing restarts from 0/0 with frame_count = 0.
- SYNC_POL = 1: same counter sequence, hsync and vsync inverted (high only in sync windows, low during reset).
